// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo read packer: flush FSM states and
// the lane-count to keep-mask conversion.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int MAX_PACK       = 16;

   typedef enum logic [1:0] {
      FL_IDLE,
      FL_DRAIN,
      FL_EMIT
   } flush_state_e;

   // Thermometer mask: the low 'lanes' bits set.
   function automatic logic [MAX_PACK-1:0] keep_mask(input int unsigned lanes);
      logic [MAX_PACK-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MAX_PACK; i++) m[i] = (i < lanes);
      return m;
   endfunction

endpackage

// File: rtl/fifo_read_packer_if.sv
// Packer-facing bundle: fifo read side, flush control and packed output stream.
interface fifo_read_packer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK       = 4
);
   logic                       fifo_r_ready;
   logic                       fifo_r_req;
   logic [DATA_WIDTH-1:0]      fifo_read_data;
   logic                       flush;
   logic                       flush_done;
   logic                       out_valid;
   logic                       out_ready;
   logic [PACK*DATA_WIDTH-1:0] out_data;
   logic [PACK-1:0]            out_keep;
   logic                       out_last;

   modport master (
      input  fifo_r_ready, fifo_read_data, flush, out_ready,
      output fifo_r_req, flush_done, out_valid, out_data, out_keep, out_last
   );

   modport slave (
      output fifo_r_ready, fifo_read_data, flush, out_ready,
      input  fifo_r_req, flush_done, out_valid, out_data, out_keep, out_last
   );
endinterface

// File: rtl/packer_out_reg.sv
// Output register slice: holds the presented word until the downstream takes it.
module packer_out_reg #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK       = 4
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load,
   input  logic [PACK*DATA_WIDTH-1:0] ld_data,
   input  logic [PACK-1:0]            ld_keep,
   input  logic                       ld_last,
   input  logic                       ready,
   output logic                       valid,
   output logic [PACK*DATA_WIDTH-1:0] data,
   output logic [PACK-1:0]            keep,
   output logic                       last,
   output logic                       free
);

   // Free when empty or being drained this cycle; callers load only when free.
   assign free = !valid || ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         keep  <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= ld_data;
         keep  <= ld_keep;
         last  <= ld_last;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_read_packer.sv
// Drains a fifo one entry per cycle and packs PACK entries into one wide word,
// with a flush path that emits a trailing partial word and a keep mask.
module fifo_read_packer
   import fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int PACK       = 4,
   localparam int LANE_W     = $clog2(PACK)
)(
   input  logic               clk,
   input  logic               reset,
   fifo_read_packer_if.master pif
);

   logic [LANE_W:0]                  lanes, fill;
   logic                             inflight;
   logic [PACK-1:0][DATA_WIDTH-1:0]  asm_q, asm_ins;
   flush_state_e                     fl_state;
   logic                             out_free, full_now, xfer, emit_ld, load, ld_last;
   logic [MAX_PACK-1:0]              mask_all;
   logic [PACK-1:0]                  ld_keep;

   // The returning entry is merged before the full test, so the word leaves on
   // the same edge its last lane lands and reads never bubble.
   always_comb begin
      fill     = lanes + {{LANE_W{1'b0}}, inflight};
      full_now = (fill == (LANE_W+1)'(PACK));
      xfer     = (fl_state == FL_IDLE) && full_now && out_free;
      emit_ld  = (fl_state == FL_EMIT) && (lanes != '0) && out_free;
      load     = xfer || emit_ld;
      ld_last  = (fl_state == FL_EMIT);
      pif.fifo_r_req = pif.fifo_r_ready && (fl_state == FL_IDLE) &&
                       ((fill < (LANE_W+1)'(PACK)) || xfer);
      asm_ins = asm_q;
      if (inflight) asm_ins[lanes[LANE_W-1:0]] = pif.fifo_read_data;
      mask_all = keep_mask(32'(fill));
      ld_keep  = mask_all[PACK-1:0];
   end

   assign pif.flush_done = ((fl_state == FL_EMIT) && (lanes == '0)) ||
                           (pif.out_valid && pif.out_ready && pif.out_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lanes    <= '0;
         inflight <= 1'b0;
         asm_q    <= '0;
         fl_state <= FL_IDLE;
      end else begin
         inflight <= pif.fifo_r_req;
         // Clearing on transfer keeps unused lanes of a partial word at zero.
         if (load) begin
            asm_q <= '0;
            lanes <= '0;
         end else if (inflight) begin
            asm_q <= asm_ins;
            lanes <= fill;
         end
         case (fl_state)
            FL_IDLE:  if (pif.flush) fl_state <= FL_DRAIN;
            FL_DRAIN: if (!inflight) fl_state <= FL_EMIT;
            FL_EMIT:  if ((lanes == '0) || out_free) fl_state <= FL_IDLE;
            default:  fl_state <= FL_IDLE;
         endcase
      end
   end

   packer_out_reg #(.DATA_WIDTH(DATA_WIDTH), .PACK(PACK)) u_out (
      .clk     (clk),
      .rst_n   (reset),
      .load    (load),
      .ld_data (asm_ins),
      .ld_keep (ld_keep),
      .ld_last (ld_last),
      .ready   (pif.out_ready),
      .valid   (pif.out_valid),
      .data    (pif.out_data),
      .keep    (pif.out_keep),
      .last    (pif.out_last),
      .free    (out_free)
   );

endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench: queue-based fifo and packing model, per-cycle output compare, and
// directed scenarios with literal expectations.
module tb_fifo_read_packer;

   localparam int DW   = 8;
   localparam int PACK = 4;
   localparam int WW   = DW * PACK;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   fifo_read_packer_if #(.DATA_WIDTH(DW), .PACK(PACK)) pif ();

   fifo_read_packer #(.DATA_WIDTH(DW), .PACK(PACK)) dut (
      .clk   (clk),
      .reset (rst_n),
      .pif   (pif)
   );

   // Bench fifo
   logic [DW-1:0] fmem [0:255];
   int wp = 0;
   int rp = 0;
   assign pif.fifo_r_ready = (wp != rp);

   // Model state: entries popped but not yet in a word, and expected words
   logic [DW-1:0]   pend [$];
   logic [WW-1:0]   exp_d [$];
   logic [PACK-1:0] exp_k [$];
   logic            exp_l [$];
   logic [WW-1:0]   log_d [$];
   logic [PACK-1:0] log_k [$];
   logic            log_l [$];
   int checks = 0, errors = 0, flush_exp = 0, flush_seen = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void push_word(input logic last);
      logic [WW-1:0] d;
      d = '0;
      for (int i = 0; i < pend.size(); i++) d[i*DW +: DW] = pend[i];
      exp_d.push_back(d);
      exp_k.push_back(PACK'((1 << pend.size()) - 1));
      exp_l.push_back(last);
      pend.delete();
   endfunction

   // Fifo pop + model: PACK pops make a full word; a flush closes the partial one
   initial begin
      pif.fifo_read_data = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            pend.delete(); exp_d.delete(); exp_k.delete(); exp_l.delete();
            flush_exp = 0;
         end else begin
            if (pif.fifo_r_req && pif.fifo_r_ready) begin
               pend.push_back(fmem[rp % 256]);
               pif.fifo_read_data <= fmem[rp % 256];
               rp <= rp + 1;
               if (pend.size() == PACK) push_word(1'b0);
            end
            if (pif.flush) begin
               if (pend.size() > 0) push_word(1'b1);
               flush_exp++;
            end
         end
      end
   end

   // Per-cycle compare against the model
   logic            pv = 1'b0;
   logic [WW-1:0]   pd;
   logic [PACK:0]   pkl;
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         pv = 1'b0;
         flush_seen = 0;
      end else begin
         if (pv) begin
            chk("hold_valid", pif.out_valid, 1);
            chk("hold_data", pif.out_data, pd);
            chk("hold_keep_last", {pif.out_keep, pif.out_last}, pkl);
         end
         if (pif.out_valid && pif.out_ready) begin
            chk("word_expected", exp_d.size() != 0, 1);
            if (exp_d.size() != 0) begin
               chk("word", {pif.out_data, pif.out_keep, pif.out_last},
                   {exp_d.pop_front(), exp_k.pop_front(), exp_l.pop_front()});
            end
            log_d.push_back(pif.out_data);
            log_k.push_back(pif.out_keep);
            log_l.push_back(pif.out_last);
         end
         if (pif.flush_done) begin
            chk("flush_done_expected", flush_seen < flush_exp, 1);
            flush_seen++;
         end
         pv  = pif.out_valid && !pif.out_ready;
         pd  = pif.out_data;
         pkl = {pif.out_keep, pif.out_last};
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [DW-1:0] v);
      fmem[wp % 256] = v;
      wp++;
   endtask

   task automatic chk_log(input string name, input int idx, input logic [WW-1:0] d,
                          input logic [PACK-1:0] k, input logic l);
      if (idx < log_d.size()) chk(name, {log_d[idx], log_k[idx], log_l[idx]}, {d, k, l});
      else chk(name, 0, 1);
   endtask

   initial begin
      logic [31:0] bits, vbits;
      int first_v, fd, acc, cnt, nb;
      pif.flush     = 1'b0;
      pif.out_ready = 1'b1;

      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", pif.out_valid, 0);
      chk("rst_req", pif.fifo_r_req, 0);
      chk("rst_data", pif.out_data, 0);
      chk("rst_keep_last", {pif.out_keep, pif.out_last}, 0);
      chk("rst_flush_done", pif.flush_done, 0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Streaming, no backpressure
      nb = log_d.size();
      for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
      bits = '0; first_v = -1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         bits[c] = pif.fifo_r_req;
         if (pif.out_valid && first_v < 0) first_v = c;
         tick(1);
      end
      chk("t1_req_pattern", bits, 32'h0000_00FF);
      chk("t1_latency", first_v, PACK + 1);
      chk_log("t1_word0", nb, 32'hA3A2A1A0, 4'hF, 1'b0);
      chk_log("t1_word1", nb + 1, 32'hA7A6A5A4, 4'hF, 1'b0);

      // Downstream stall until cycle 20
      nb = log_d.size();
      pif.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (pif.fifo_r_req) cnt++;
         tick(1);
      end
      chk("t2_pops", cnt, 8);
      chk("t2_stalled_valid", pif.out_valid, 1);
      pif.out_ready = 1'b1;
      tick(12);
      chk_log("t2_word0", nb, 32'hA3A2A1A0, 4'hF, 1'b0);
      chk_log("t2_word1", nb + 1, 32'hA7A6A5A4, 4'hF, 1'b0);

      // Partial word via flush
      nb = log_d.size();
      push(8'hB0); push(8'hB1); push(8'hB2);
      tick(8);
      chk("t3_no_partial_out", pif.out_valid, 0);
      pif.flush = 1'b1;
      fd = -1; acc = -1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (pif.flush_done && fd < 0) fd = c;
         if (pif.out_valid && pif.out_ready && acc < 0) acc = c;
         tick(1);
         pif.flush = 1'b0;
      end
      chk("t3_done_cycle", fd, 3);
      chk("t3_accept_cycle", acc, 3);
      chk_log("t3_word", nb, 32'h00B2B1B0, 4'b0111, 1'b1);

      // Flush with nothing buffered
      nb = log_d.size();
      pif.flush = 1'b1;
      bits = '0; vbits = '0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         bits[c]  = pif.flush_done;
         vbits[c] = pif.out_valid;
         tick(1);
         pif.flush = 1'b0;
      end
      chk("t4_done_bits", bits, 32'h0000_0004);
      chk("t4_no_valid", vbits, 0);
      chk("t4_no_word", log_d.size() - nb, 0);

      // Flush on the cycle a read is accepted
      nb = log_d.size();
      push(8'hC0); push(8'hC1);
      tick(5);
      push(8'hC2);
      pif.flush = 1'b1;
      fd = -1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 0) chk("t5_req_with_flush", pif.fifo_r_req, 1);
         if (pif.flush_done && fd < 0) fd = c;
         tick(1);
         pif.flush = 1'b0;
      end
      chk("t5_done_cycle", fd, 4);
      chk_log("t5_word", nb, 32'h00C2C1C0, 4'b0111, 1'b1);

      // Asynchronous reset with a held word and two buffered lanes
      pif.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) push(8'hD0 + 8'(i));
      tick(9);
      @(negedge clk);
      chk("t6_valid_before", pif.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_drop", pif.out_valid, 0);
      chk("t6_async_keep", pif.out_keep, 0);
      tick(2);
      rst_n = 1'b1;
      nb = log_d.size();
      pif.out_ready = 1'b1;
      push(8'hE0); push(8'hE1); push(8'hE2); push(8'hE3);
      tick(10);
      chk_log("t6_post_reset_word", nb, 32'hE3E2E1E0, 4'hF, 1'b0);
      chk("t6_one_word", log_d.size() - nb, 1);

      tick(3);
      chk("end_model_drained", exp_d.size(), 0);
      chk("end_flush_balance", flush_seen, flush_exp);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
